alu_issue_stage: RTL

Execute-stage front end of the five-stage MIPS pipeline. It sits between the ID/EX register and the EX/MEM register and drives the ALU's `input1`/`input2`/`ALUCtr` ports. It consumes the ALU's `ALURes`/`zero` results. It decodes ALUOp/funct into ALUCtr, selects forwarded operands, resolves beq/jr, and registers the EX/MEM payload. A two-state squash FSM suppresses the wrong-path instruction that follows a taken control transfer.

---
 rtl/alu_pkg.sv | 61 ++++++
 rtl/alu_ctr_dec.sv | 39 +++
 rtl/alu_issue_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage issue logic: ALUCtr, ALUOp, funct, forward selects,
// squash FSM states and the EX/MEM payload.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTR_W  = 4;
  localparam int unsigned AOP_W  = 3;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned SH_W   = 5;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned FWD_W  = 2;

  localparam logic [CTR_W-1:0] CTR_AND = 4'b0000;
  localparam logic [CTR_W-1:0] CTR_OR  = 4'b0001;
  localparam logic [CTR_W-1:0] CTR_ADD = 4'b0010;
  localparam logic [CTR_W-1:0] CTR_SLL = 4'b0011;
  localparam logic [CTR_W-1:0] CTR_SRL = 4'b0100;
  localparam logic [CTR_W-1:0] CTR_JR  = 4'b0101;
  localparam logic [CTR_W-1:0] CTR_SUB = 4'b0110;
  localparam logic [CTR_W-1:0] CTR_SLT = 4'b0111;
  localparam logic [CTR_W-1:0] CTR_NOR = 4'b1100;
  localparam logic [CTR_W-1:0] CTR_ILL = 4'b1111;

  localparam logic [AOP_W-1:0] AOP_ADD   = 3'b000;
  localparam logic [AOP_W-1:0] AOP_SUB   = 3'b001;
  localparam logic [AOP_W-1:0] AOP_RTYPE = 3'b010;
  localparam logic [AOP_W-1:0] AOP_AND   = 3'b011;
  localparam logic [AOP_W-1:0] AOP_OR    = 3'b100;
  localparam logic [AOP_W-1:0] AOP_SLT   = 3'b101;

  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;
  localparam logic [FN_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FN_W-1:0] FN_SLL = 6'b000000;
  localparam logic [FN_W-1:0] FN_SRL = 6'b000010;
  localparam logic [FN_W-1:0] FN_JR  = 6'b001000;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              illegal;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] store_data;
    logic [RD_W-1:0]   rd;
  } ex_mem_t;

endpackage

// File: rtl/alu_ctr_dec.sv
// Combinational ALUOp/funct to ALUCtr decoder; unknown encodings map to CTR_ILL and flag illegal.
module alu_ctr_dec
  import alu_pkg::*;
(
  input  logic [AOP_W-1:0] i_aluop,
  input  logic [FN_W-1:0]  i_funct,
  output logic [CTR_W-1:0] o_alu_ctr_c,
  output logic             o_illegal_c
);

  always_comb begin
    o_alu_ctr_c = CTR_ILL;
    o_illegal_c = 1'b1;
    case (i_aluop)
      AOP_ADD: begin o_alu_ctr_c = CTR_ADD; o_illegal_c = 1'b0; end
      AOP_SUB: begin o_alu_ctr_c = CTR_SUB; o_illegal_c = 1'b0; end
      AOP_AND: begin o_alu_ctr_c = CTR_AND; o_illegal_c = 1'b0; end
      AOP_OR:  begin o_alu_ctr_c = CTR_OR;  o_illegal_c = 1'b0; end
      AOP_SLT: begin o_alu_ctr_c = CTR_SLT; o_illegal_c = 1'b0; end
      AOP_RTYPE: begin
        o_illegal_c = 1'b0;
        case (i_funct)
          FN_ADD:  o_alu_ctr_c = CTR_ADD;
          FN_SUB:  o_alu_ctr_c = CTR_SUB;
          FN_AND:  o_alu_ctr_c = CTR_AND;
          FN_OR:   o_alu_ctr_c = CTR_OR;
          FN_SLT:  o_alu_ctr_c = CTR_SLT;
          FN_NOR:  o_alu_ctr_c = CTR_NOR;
          FN_SLL:  o_alu_ctr_c = CTR_SLL;
          FN_SRL:  o_alu_ctr_c = CTR_SRL;
          FN_JR:   o_alu_ctr_c = CTR_JR;
          default: begin o_alu_ctr_c = CTR_ILL; o_illegal_c = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// EX-stage front end: ALU control decode, operand forwarding, beq/jr resolution,
// EX/MEM payload register and the wrong-path squash FSM.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [AOP_W-1:0] id_aluop,
  input  logic [FN_W-1:0]  id_funct,
  input  logic [SH_W-1:0]  id_shamt,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic             id_alusrc,
  input  logic             id_branch,
  input  logic [DW-1:0]    id_pc4,
  input  logic [RD_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic [FWD_W-1:0] fwd_a_sel,
  input  logic [FWD_W-1:0] fwd_b_sel,
  input  logic [DW-1:0]    mem_fwd_data,
  input  logic [DW-1:0]    wb_fwd_data,
  input  logic             stall,
  input  logic             flush,
  output logic [DW-1:0]    alu_in1,
  output logic [DW-1:0]    alu_in2,
  output logic [CTR_W-1:0] alu_ctr,
  input  logic [DW-1:0]    alu_res,
  input  logic             alu_zero,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_illegal,
  output logic [DW-1:0]    ex_alu_res,
  output logic [DW-1:0]    ex_store_data,
  output logic [RD_W-1:0]  ex_rd,
  output logic             br_taken,
  output logic             jr_taken,
  output logic [DW-1:0]    br_target,
  output logic [DW-1:0]    jr_target
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CTR_W-1:0] w_ctr;
  logic             w_illegal;
  logic [DW-1:0]    w_a_fwd;
  logic [DW-1:0]    w_b_fwd;
  logic             w_is_shift;
  logic             w_is_jr;
  logic             w_eff_v;
  logic             w_br_take;
  logic             w_jr_take;
  logic [DW-1:0]    w_br_target;
  ex_mem_t          w_ex_nxt;
  ex_mem_t          r_ex;
  logic             r_br_taken;
  logic             r_jr_taken;
  logic [DW-1:0]    r_br_target;
  logic [DW-1:0]    r_jr_target;

  alu_ctr_dec u_dec (
    .i_aluop     (id_aluop),
    .i_funct     (id_funct),
    .o_alu_ctr_c (w_ctr),
    .o_illegal_c (w_illegal)
  );

  always_comb begin
    w_a_fwd = id_rs_data;
    case (fwd_a_sel)
      FWD_RF:  w_a_fwd = id_rs_data;
      FWD_MEM: w_a_fwd = mem_fwd_data;
      FWD_WB:  w_a_fwd = wb_fwd_data;
      default: w_a_fwd = id_rs_data;
    endcase
  end

  always_comb begin
    w_b_fwd = id_rt_data;
    case (fwd_b_sel)
      FWD_RF:  w_b_fwd = id_rt_data;
      FWD_MEM: w_b_fwd = mem_fwd_data;
      FWD_WB:  w_b_fwd = wb_fwd_data;
      default: w_b_fwd = id_rt_data;
    endcase
  end

  // Shifts take the value from rt and the amount from shamt.
  assign w_is_shift = (w_ctr == CTR_SLL) || (w_ctr == CTR_SRL);
  assign w_is_jr    = (w_ctr == CTR_JR);
  assign alu_ctr    = w_ctr;
  assign alu_in1    = w_is_shift ? w_b_fwd : w_a_fwd;
  assign alu_in2    = w_is_shift ? DW'(id_shamt) : (id_alusrc ? id_imm : w_b_fwd);

  assign w_eff_v     = id_valid && (r_state == ST_RUN);
  assign w_br_take   = w_eff_v && id_branch && alu_zero;
  assign w_jr_take   = w_eff_v && w_is_jr;
  assign w_br_target = id_pc4 + (id_imm << 2);

  always_comb begin
    w_ex_nxt            = '0;
    w_ex_nxt.valid      = w_eff_v;
    w_ex_nxt.regwrite   = w_eff_v && id_regwrite && !w_is_jr;
    w_ex_nxt.memread    = w_eff_v && id_memread;
    w_ex_nxt.memwrite   = w_eff_v && id_memwrite;
    w_ex_nxt.illegal    = w_eff_v && w_illegal;
    w_ex_nxt.alu_res    = alu_res;
    w_ex_nxt.store_data = w_b_fwd;
    w_ex_nxt.rd         = id_rd;
  end

  // Squash FSM: one slot after a taken redirect is killed; stalls freeze it, flush clears it.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_RUN;
    end else if (!stall) begin
      case (r_state)
        ST_RUN:    if (w_br_take || w_jr_take) w_state_nxt = ST_SQUASH;
        ST_SQUASH: w_state_nxt = ST_RUN;
        default:   w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= '0;
      r_br_taken  <= 1'b0;
      r_jr_taken  <= 1'b0;
      r_br_target <= '0;
      r_jr_target <= '0;
    end else if (flush) begin
      r_ex.valid    <= 1'b0;
      r_ex.regwrite <= 1'b0;
      r_ex.memread  <= 1'b0;
      r_ex.memwrite <= 1'b0;
      r_ex.illegal  <= 1'b0;
      r_br_taken    <= 1'b0;
      r_jr_taken    <= 1'b0;
    end else if (stall) begin
      r_br_taken <= 1'b0;
      r_jr_taken <= 1'b0;
    end else begin
      r_ex        <= w_ex_nxt;
      r_br_taken  <= w_br_take;
      r_jr_taken  <= w_jr_take;
      r_br_target <= w_br_target;
      r_jr_target <= w_a_fwd;
    end
  end

  assign ex_valid      = r_ex.valid;
  assign ex_regwrite   = r_ex.regwrite;
  assign ex_memread    = r_ex.memread;
  assign ex_memwrite   = r_ex.memwrite;
  assign ex_illegal    = r_ex.illegal;
  assign ex_alu_res    = r_ex.alu_res;
  assign ex_store_data = r_ex.store_data;
  assign ex_rd         = r_ex.rd;
  assign br_taken      = r_br_taken;
  assign jr_taken      = r_jr_taken;
  assign br_target     = r_br_target;
  assign jr_target     = r_jr_target;

endmodule
